// File: rtl/ps2_kb_mmio.sv
// ---------------------------------------------------------------------------
// ps2_kb_mmio
//
// Memory-mapped PS/2 keyboard controller. Receives device-to-host PS/2
// frames (start, 8 data bits LSB-first, odd parity, stop), buffers the
// scan codes in a small FIFO and presents them to the CPU through two
// word-aligned registers:
//   BASE_ADDR + 0 : DATA  {23'b0, nonempty, head_byte}; a read pops
//   BASE_ADDR + 4 : STAT  flags, count and interrupt enable; W1C flags
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   addr, re, we      CPU byte address and read/write strobes
//   wdata, rdata      CPU write data / combinational read data
//   sel               address falls inside this block's 8-byte window
//   irq               registered interrupt request
//   ps2_clk, ps2_data raw, asynchronous PS/2 lines
// ---------------------------------------------------------------------------
module ps2_kb_mmio #(
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_2000_0010,
    parameter int          FIFO_DEPTH     = 8,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq,
    input  logic        ps2_clk,
    input  logic        ps2_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    // Synchronisers and edge detector
    logic ps2_clk_meta_q,  ps2_clk_meta_d;
    logic ps2_clk_sync_q,  ps2_clk_sync_d;
    logic ps2_clk_prev_q,  ps2_clk_prev_d;
    logic ps2_data_meta_q, ps2_data_meta_d;
    logic ps2_data_sync_q, ps2_data_sync_d;
    logic fall;

    // Receiver
    logic [1:0]    state_q,   state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          par_q,     par_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          push_req;
    logic          perr_set;
    logic          ferr_set;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          nonempty;
    logic          full;
    logic          push_ok;
    logic          pop;
    logic          ovf_set;

    // Status / interrupt
    logic ovf_q,  ovf_d;
    logic perr_q, perr_d;
    logic ferr_q, ferr_d;
    logic ie_q,   ie_d;
    logic irq_q,  irq_d;

    // Bus decode
    logic       data_rd;
    logic       stat_wr;
    logic [7:0] head_byte;
    logic       unused_bits;

    assign sel     = (addr[63:3] == BASE_ADDR[63:3]);
    assign data_rd = sel & ~addr[2] & re;
    assign stat_wr = sel &  addr[2] & we;
    assign fall    = ps2_clk_prev_q & ~ps2_clk_sync_q;
    assign irq     = irq_q;

    // Only a handful of wdata bits and no byte-offset bits carry meaning.
    assign unused_bits = ^{wdata[31:17], wdata[15:5], wdata[1:0], addr[1:0]};

    // -----------------------------------------------------------------------
    // Synchroniser next state
    // -----------------------------------------------------------------------
    always_comb begin
        ps2_clk_meta_d  = ps2_clk;
        ps2_clk_sync_d  = ps2_clk_meta_q;
        ps2_clk_prev_d  = ps2_clk_sync_q;
        ps2_data_meta_d = ps2_data;
        ps2_data_sync_d = ps2_data_meta_q;
    end

    // -----------------------------------------------------------------------
    // Frame receiver and inactivity timeout
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push_req  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;

        // Counter only runs while a frame is in progress.
        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    // A high start bit is treated as line noise.
                    if (!ps2_data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = ps2_data_sync_q;
                    state_d = ST_STOP;
                end
                default: begin
                    // A missing stop bit is reported as a framing error even
                    // if the parity is also wrong.
                    state_d = ST_IDLE;
                    if (!ps2_data_sync_q) begin
                        ferr_set = 1'b1;
                    end else if (^{shift_q, par_q}) begin
                        push_req = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
            state_d  = ST_IDLE;
            ferr_set = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO, status flags and interrupt
    // -----------------------------------------------------------------------
    always_comb begin
        nonempty = (count_q != '0);
        full     = (count_q == CNT_FULL);
        pop      = data_rd & nonempty;
        // A simultaneous pop frees the slot, so a push into a full FIFO
        // is accepted in that cycle.
        push_ok  = push_req & (~full | pop);
        ovf_set  = push_req & full & ~pop;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // Set events take priority over a same-cycle write-1-to-clear.
        ovf_d  = ovf_set  | (ovf_q  & ~(stat_wr & wdata[2]));
        perr_d = perr_set | (perr_q & ~(stat_wr & wdata[3]));
        ferr_d = ferr_set | (ferr_q & ~(stat_wr & wdata[4]));
        ie_d   = stat_wr ? wdata[16] : ie_q;

        irq_d = ie_d & ((count_d != '0) | ovf_d | perr_d | ferr_d);
    end

    // -----------------------------------------------------------------------
    // Read data
    // -----------------------------------------------------------------------
    always_comb begin
        head_byte = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
        rdata     = 32'h0;
        if (sel) begin
            if (!addr[2]) begin
                rdata = {23'b0, (count_q != '0), head_byte};
            end else begin
                rdata = {15'b0, ie_q, 8'(count_q), 3'b0,
                         ferr_q, perr_q, ovf_q,
                         (count_q == CNT_FULL), (count_q != '0)};
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            ps2_clk_meta_q  <= 1'b0;
            ps2_clk_sync_q  <= 1'b0;
            ps2_clk_prev_q  <= 1'b0;
            ps2_data_meta_q <= 1'b0;
            ps2_data_sync_q <= 1'b0;
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_q           <= 1'b0;
            tmo_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            ovf_q           <= 1'b0;
            perr_q          <= 1'b0;
            ferr_q          <= 1'b0;
            ie_q            <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            ps2_clk_meta_q  <= ps2_clk_meta_d;
            ps2_clk_sync_q  <= ps2_clk_sync_d;
            ps2_clk_prev_q  <= ps2_clk_prev_d;
            ps2_data_meta_q <= ps2_data_meta_d;
            ps2_data_sync_q <= ps2_data_sync_d;
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_q           <= par_d;
            tmo_q           <= tmo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            ovf_q           <= ovf_d;
            perr_q          <= perr_d;
            ferr_q          <= ferr_d;
            ie_q            <= ie_d;
            irq_q           <= irq_d;
        end
    end

    // NOTE: the storage array has no reset; an empty count makes its
    // contents unobservable, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ps2_kb_mmio.sv
// ---------------------------------------------------------------------------
// tb_ps2_kb_mmio
//
// Self-checking bench for ps2_kb_mmio. A PS/2 device model drives frames
// onto ps2_clk/ps2_data; a CPU model reads and writes the two registers.
// Expected values come from a behavioural model: a byte queue plus the
// sticky flags and ie bit, updated from the frame rules after each action.
// ---------------------------------------------------------------------------
module tb_ps2_kb_mmio;

    localparam logic [63:0] BASE    = 64'h0000_0000_2000_0010;
    localparam int          DEPTH   = 8;
    localparam int          TIMEOUT = 4096;
    localparam int          HALF    = 15;  // clk cycles per PS/2 half period

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;
    logic        ps2_clk;
    logic        ps2_data;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    logic [7:0] mq[$];
    bit         m_ovf, m_perr, m_ferr, m_ie;

    ps2_kb_mmio #(
        .BASE_ADDR      (BASE),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .sel      (sel),
        .irq      (irq),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat();
        int cnt;
        cnt = mq.size();
        return {15'b0, m_ie, 8'(cnt), 3'b0, m_ferr, m_perr, m_ovf,
                (cnt == DEPTH), (cnt != 0)};
    endfunction

    function automatic logic [31:0] exp_irq();
        return {31'b0, m_ie & ((mq.size() != 0) | m_ovf | m_perr | m_ferr)};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ie   = 1'b0;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else                    mq.push_back(b);
    endfunction

    // ---------------- PS/2 device model ----------------
    task automatic ps2_bit(input logic v);
        @(posedge clk); #1;
        ps2_data = v;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // kind: 0 good frame, 1 wrong parity, 2 stop bit low.
    // With pop_on_stop the CPU reads DATA in the very cycle the receiver
    // sees the stop-bit fall (two synchroniser stages after the raw edge).
    task automatic send_frame(input logic [7:0] b, input int kind,
                              input bit pop_on_stop, output logic [31:0] popped);
        logic par;
        logic stop;
        par  = ~^b;
        if (kind == 1) par = ~par;
        stop = (kind == 2) ? 1'b0 : 1'b1;
        popped = '0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        if (!pop_on_stop) begin
            ps2_bit(stop);
        end else begin
            @(posedge clk); #1;
            ps2_data = stop;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            @(posedge clk);
            @(posedge clk); #1;
            addr = BASE;
            re   = 1'b1;
            #1 popped = rdata;
            @(posedge clk); #1;
            re   = 1'b0;
            addr = '0;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        if (pop_on_stop && mq.size() != 0) void'(mq.pop_front());
        if (kind == 0)      model_push(b);
        else if (kind == 1) m_perr = 1'b1;
        else                m_ferr = 1'b1;
    endtask

    // ---------------- CPU model ----------------
    task automatic cpu_read(input logic is_stat, output logic [31:0] v);
        @(posedge clk); #1;
        addr = BASE + (is_stat ? 64'd4 : 64'd0);
        re   = 1'b1;
        #1 v = rdata;
        @(posedge clk); #1;
        re   = 1'b0;
        addr = '0;
    endtask

    task automatic cpu_write(input logic is_stat, input logic [31:0] d);
        @(posedge clk); #1;
        addr  = BASE + (is_stat ? 64'd4 : 64'd0);
        we    = 1'b1;
        wdata = d;
        @(posedge clk); #1;
        we    = 1'b0;
        wdata = '0;
        addr  = '0;
        if (is_stat) begin
            if (d[2]) m_ovf  = 1'b0;
            if (d[3]) m_perr = 1'b0;
            if (d[4]) m_ferr = 1'b0;
            m_ie = d[16];
        end
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] v, e;
        e = (mq.size() != 0) ? {23'b0, 1'b1, mq[0]} : 32'h0;
        cpu_read(1'b0, v);
        check(tag, v, e);
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic stat_check(input string tag);
        logic [31:0] v;
        cpu_read(1'b1, v);
        check(tag, v, exp_stat());
        check({tag, "_irq"}, {31'b0, irq}, exp_irq());
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] v;
        reset    = 1'b1;
        addr     = '0;
        re       = 1'b0;
        we       = 1'b0;
        wdata    = '0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();

        // ---- reset state and decode ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0);
        addr = BASE + 64'd4;
        #1 check("rst_stat", rdata, 32'h0);
        check("sel_stat", {31'b0, sel}, 32'h1);
        addr = BASE + 64'd8;
        #1 check("sel_next", {31'b0, sel}, 32'h0);
        addr = BASE - 64'd8;
        #1 check("sel_prev", {31'b0, sel}, 32'h0);
        addr = 64'h0000_0000_2000_0014;
        #1 check("sel_lit", {31'b0, sel}, 32'h1);
        addr = '0;
        #1 reset = 1'b0;
        repeat (TIMEOUT + 10) @(posedge clk);  // idle must never time out
        stat_check("idle_stat");

        // ---- good frame 0x1C ----
        send_frame(8'h1C, 0, 1'b0, v);
        cpu_read(1'b1, v);
        check("f1c_stat_lit", v, 32'h0000_0101);
        cpu_read(1'b0, v);
        check("f1c_data_lit", v, 32'h0000_011C);
        void'(mq.pop_front());
        cpu_read(1'b1, v);
        check("f1c_after_pop", v, 32'h0000_0000);
        cpu_write(1'b0, 32'hFFFF_FFFF);  // DATA writes are ignored
        stat_check("data_wr_ignored");

        // ---- bad parity ----
        send_frame(8'h1C, 1, 1'b0, v);
        cpu_read(1'b1, v);
        check("perr_stat_lit", v, 32'h0000_0008);
        cpu_write(1'b1, 32'h0000_0008);
        cpu_read(1'b1, v);
        check("perr_clr_lit", v, 32'h0000_0000);

        // ---- overflow ----
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0, v);
        cpu_read(1'b1, v);
        check("ovf_stat_lit", v, 32'h0000_0807);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(1'b0, v);
            check("ovf_pop", v, 32'h0000_0100 | 32'(i));
            void'(mq.pop_front());
        end
        read_data_check("ovf_empty_read");
        stat_check("ovf_sticky");
        cpu_write(1'b1, 32'h0000_0004);
        stat_check("ovf_clr");

        // ---- interrupt ----
        cpu_write(1'b1, 32'h0001_0000);
        check("irq_idle", {31'b0, irq}, 32'h0);
        send_frame(8'hF0, 0, 1'b0, v);
        check("irq_rise", {31'b0, irq}, 32'h1);
        read_data_check("irq_pop");
        @(posedge clk); #1;
        check("irq_fall", {31'b0, irq}, 32'h0);
        cpu_write(1'b1, 32'h0000_001C);

        // ---- timeout on a partial frame ----
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TIMEOUT + 2) @(posedge clk);
        #1 m_ferr = 1'b1;
        cpu_read(1'b1, v);
        check("tmo_stat_lit", v, 32'h0000_0010);
        cpu_write(1'b1, 32'h0000_0010);
        send_frame(8'h5A, 0, 1'b0, v);
        cpu_read(1'b0, v);
        check("tmo_next_lit", v, 32'h0000_015A);
        void'(mq.pop_front());

        // ---- push and pop in the same cycle while full ----
        for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i), 0, 1'b0, v);
        stat_check("full_before");
        send_frame(8'h38, 0, 1'b1, v);
        check("full_coinc_pop", v, 32'h0000_0130);
        cpu_read(1'b1, v);
        check("full_coinc_lit", v, 32'h0000_0803);
        for (int i = 1; i <= 8; i++) begin
            cpu_read(1'b0, v);
            check("full_drain", v, 32'h0000_0130 + 32'(i));
            void'(mq.pop_front());
        end

        // ---- reset in the middle of a frame ----
        send_frame(8'h77, 0, 1'b0, v);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        do_reset();
        repeat (HALF) @(posedge clk);
        send_frame(8'h29, 0, 1'b0, v);
        cpu_read(1'b1, v);
        check("mid_rst_stat_lit", v, 32'h0000_0101);
        cpu_read(1'b0, v);
        check("mid_rst_data_lit", v, 32'h0000_0129);
        void'(mq.pop_front());
        stat_check("mid_rst_empty");

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    int r, kind;
                    r    = $urandom_range(0, 9);
                    kind = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
                    send_frame(8'($urandom), kind, 1'b0, v);
                    check("rnd_frame_irq", {31'b0, irq}, exp_irq());
                end
                1: read_data_check("rnd_data");
                2: begin
                    logic [31:0] w;
                    w = $urandom & 32'h0001_001C;
                    cpu_write(1'b1, w);
                    check("rnd_wr_irq", {31'b0, irq}, exp_irq());
                end
                default: stat_check("rnd_stat");
            endcase
        end
        while (mq.size() != 0) read_data_check("rnd_drain");
        stat_check("rnd_final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
